// File: rtl/alu_reservation_station.sv
// Reservation station feeding the integer ALU: holds dispatched ops, snoops the CDB, issues the oldest ready entry.
// Build option: define RS_CDB_BYPASS_EN to let a CDB broadcast complete an entry and issue it in the same cycle.
module alu_reservation_station #(
  parameter int DATA_WIDTH   = 32,
  parameter int TAG_WIDTH    = 6,
  parameter int NUM_ENTRIES  = 8,
  parameter int OPCODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH = 3,
  parameter int FUNCT7_WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  logic [OPCODE_WIDTH-1:0]       disp_opcode,
  input  logic [FUNCT3_WIDTH-1:0]       disp_funct3,
  input  logic [FUNCT7_WIDTH-1:0]       disp_funct7,
  input  logic                          disp_src1_rdy,
  input  logic                          disp_src2_rdy,
  input  logic [TAG_WIDTH-1:0]          disp_src1_tag,
  input  logic [TAG_WIDTH-1:0]          disp_src2_tag,
  input  logic [DATA_WIDTH-1:0]         disp_src1_val,
  input  logic [DATA_WIDTH-1:0]         disp_src2_val,
  input  logic [TAG_WIDTH-1:0]          disp_dst_tag,
  input  logic                          cdb_valid,
  input  logic [TAG_WIDTH-1:0]          cdb_tag,
  input  logic [DATA_WIDTH-1:0]         cdb_val,
  output logic                          iss_valid,
  input  logic                          iss_ready,
  output logic [DATA_WIDTH-1:0]         iss_operand1,
  output logic [DATA_WIDTH-1:0]         iss_operand2,
  output logic [OPCODE_WIDTH-1:0]       iss_opcode,
  output logic [FUNCT3_WIDTH-1:0]       iss_funct3,
  output logic [FUNCT7_WIDTH-1:0]       iss_funct7,
  output logic [TAG_WIDTH-1:0]          iss_dst_tag,
  output logic [$clog2(NUM_ENTRIES):0]  occupancy
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OCC_W = IDX_W + 1;

`ifdef RS_CDB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic                    valid;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [FUNCT3_WIDTH-1:0] funct3;
    logic [FUNCT7_WIDTH-1:0] funct7;
    logic [TAG_WIDTH-1:0]    dst_tag;
    logic                    src1_rdy;
    logic [TAG_WIDTH-1:0]    src1_tag;
    logic [DATA_WIDTH-1:0]   src1_val;
    logic                    src2_rdy;
    logic [TAG_WIDTH-1:0]    src2_tag;
    logic [DATA_WIDTH-1:0]   src2_val;
    logic [IDX_W-1:0]        age;
  } entry_t;

  entry_t            ent_q [NUM_ENTRIES];
  logic [OCC_W-1:0]  occ_q;
  logic              hold_q;
  logic [IDX_W-1:0]  hold_idx_q;

  logic [NUM_ENTRIES-1:0] cand;
  logic                   sel_found;
  logic [IDX_W-1:0]       sel_idx;
  logic [IDX_W-1:0]       sel_age;
  logic [IDX_W-1:0]       free_idx;
  logic [DATA_WIDTH-1:0]  sel_op1;
  logic [DATA_WIDTH-1:0]  sel_op2;
  logic                   disp_fire;
  logic                   iss_fire;
  logic                   disp_hit1;
  logic                   disp_hit2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // once valid is raised the presented payload holds until that edge (ready never depends on valid).
  assign disp_ready = rst_n && (occ_q < OCC_W'(NUM_ENTRIES));
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign iss_fire   = iss_valid && iss_ready;
  assign occupancy  = occ_q;

  assign disp_hit1 = cdb_valid && !disp_src1_rdy && (disp_src1_tag == cdb_tag);
  assign disp_hit2 = cdb_valid && !disp_src2_rdy && (disp_src2_tag == cdb_tag);

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cand[i] = ent_q[i].valid
        && (ent_q[i].src1_rdy || (BYPASS && cdb_valid && ent_q[i].src1_tag == cdb_tag))
        && (ent_q[i].src2_rdy || (BYPASS && cdb_valid && ent_q[i].src2_tag == cdb_tag));
    end
  end

  // Oldest candidate wins, unless an entry was presented and stalled: it stays put until taken.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (cand[i] && (!sel_found || ent_q[i].age > sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = ent_q[i].age;
      end
    end
    if (hold_q) begin
      sel_found = 1'b1;
      sel_idx   = hold_idx_q;
    end
    sel_age = ent_q[sel_idx].age;
    sel_op1 = ent_q[sel_idx].src1_val;
    sel_op2 = ent_q[sel_idx].src2_val;
    if (BYPASS && !ent_q[sel_idx].src1_rdy) sel_op1 = cdb_val;
    if (BYPASS && !ent_q[sel_idx].src2_rdy) sel_op2 = cdb_val;
  end

  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) free_idx = IDX_W'(i);
    end
  end

  assign iss_valid    = sel_found;
  assign iss_operand1 = sel_found ? sel_op1 : '0;
  assign iss_operand2 = sel_found ? sel_op2 : '0;
  assign iss_opcode   = sel_found ? ent_q[sel_idx].opcode  : '0;
  assign iss_funct3   = sel_found ? ent_q[sel_idx].funct3  : '0;
  assign iss_funct7   = sel_found ? ent_q[sel_idx].funct7  : '0;
  assign iss_dst_tag  = sel_found ? ent_q[sel_idx].dst_tag : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i].valid <= 1'b0;
      occ_q      <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (ent_q[i].valid) begin
          if (iss_fire && sel_idx == IDX_W'(i)) begin
            ent_q[i].valid <= 1'b0;
          end else begin
            if (cdb_valid && !ent_q[i].src1_rdy && ent_q[i].src1_tag == cdb_tag) begin
              ent_q[i].src1_rdy <= 1'b1;
              ent_q[i].src1_val <= cdb_val;
            end
            if (cdb_valid && !ent_q[i].src2_rdy && ent_q[i].src2_tag == cdb_tag) begin
              ent_q[i].src2_rdy <= 1'b1;
              ent_q[i].src2_val <= cdb_val;
            end
            // Ages are kept as a dense rank so they stay unique and never wrap.
            ent_q[i].age <= ent_q[i].age + IDX_W'(disp_fire)
                          - IDX_W'(iss_fire && ent_q[i].age > sel_age);
          end
        end else if (disp_fire && free_idx == IDX_W'(i)) begin
          ent_q[i].valid    <= 1'b1;
          ent_q[i].opcode   <= disp_opcode;
          ent_q[i].funct3   <= disp_funct3;
          ent_q[i].funct7   <= disp_funct7;
          ent_q[i].dst_tag  <= disp_dst_tag;
          ent_q[i].src1_rdy <= disp_src1_rdy || disp_hit1;
          ent_q[i].src1_tag <= disp_src1_tag;
          ent_q[i].src1_val <= disp_hit1 ? cdb_val : disp_src1_val;
          ent_q[i].src2_rdy <= disp_src2_rdy || disp_hit2;
          ent_q[i].src2_tag <= disp_src2_tag;
          ent_q[i].src2_val <= disp_hit2 ? cdb_val : disp_src2_val;
          ent_q[i].age      <= '0;
        end
      end
      case ({disp_fire, iss_fire})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      hold_q     <= iss_valid && !iss_ready;
      hold_idx_q <= sel_idx;
    end
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Issue queue that sits directly upstream of the integer ALU in the out-of-order core.
- Holds dispatched RV32I register and immediate ALU ops (opcode 0110011/0010011) until both operands are available.
- Snoops the common data bus (CDB) for results it is waiting on.
- Issues the oldest ready entry per cycle to the ALU as operand1/operand2/opcode/funct3/funct7 plus the destination tag.

Parameters:
- DATA_WIDTH, 32, operand/result width
- TAG_WIDTH, 6, physical/ROB tag width
- NUM_ENTRIES, 8, queue depth (power of two, >=2)
- OPCODE_WIDTH, 7, opcode field width
- FUNCT3_WIDTH, 3, funct3 field width
- FUNCT7_WIDTH, 7, funct7 field width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  synchronous squash of all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  a free entry exists
- disp_opcode / disp_funct3 / disp_funct7  in  OPCODE/FUNCT3/FUNCT7_WIDTH  decoded fields, passed through unchanged
- disp_src1_rdy, disp_src2_rdy  in  1 each  operand value valid
- disp_src1_tag, disp_src2_tag  in  TAG_WIDTH each  producer tag when not ready
- disp_src1_val, disp_src2_val  in  DATA_WIDTH each  operand value; I-type places the sign-extended immediate in src2 with src2_rdy=1
- disp_dst_tag  in  TAG_WIDTH  result tag
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_WIDTH  broadcast tag
- cdb_val  in  DATA_WIDTH  broadcast value
- iss_valid  out  1  an entry is presented to the ALU
- iss_ready  in  1  ALU accepts
- iss_operand1, iss_operand2  out  DATA_WIDTH each  operands
- iss_opcode / iss_funct3 / iss_funct7  out  field widths  op fields
- iss_dst_tag  out  TAG_WIDTH  result tag
- occupancy  out  $clog2(NUM_ENTRIES)+1  number of valid entries

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous, active-low, on rst_n.
- Reset (rst_n=0 at an edge): all entries invalid; occupancy=0; iss_valid=0. While rst_n is low, disp_ready=0. The first edge after release accepts dispatch.
- Entry state: valid, op fields, dst_tag, and per source: rdy, tag, val. Also an age counter of $clog2(NUM_ENTRIES) bits.
- disp_ready = occupancy < NUM_ENTRIES, computed from registered state only. A slot freed by issue this cycle is not reusable until the next cycle.
- Dispatch fire (disp_valid & disp_ready & !flush):
  - Write the lowest-index invalid entry with age=0.
  - Increment the age of every other valid entry not issuing this cycle.
  - Ages stay unique; the larger age is older.
- Same-cycle CDB on dispatch: if cdb_valid and a not-ready disp_srcN_tag equals cdb_tag, the entry is written with srcN_rdy=1 and val=cdb_val.
- Wakeup: each cycle, every valid entry with srcN_rdy=0 and srcN_tag==cdb_tag (cdb_valid=1) captures cdb_val and sets srcN_rdy=1. Both sources may wake on the same broadcast.
- Select: combinational over registered state.
  - Candidates are entries with valid & src1_rdy & src2_rdy; pick the maximum age.
  - iss_valid=1 iff a candidate exists; outputs are driven from that entry.
  - When iss_valid=0, all iss_* data outputs are 0.
- Issue fire (iss_valid & iss_ready): the selected entry is invalidated at the edge.
- Stall (iss_valid & !iss_ready): state is held and outputs stay stable. A newly older-ready entry may not displace the presented one; the presented entry is latched until accepted.
- Occupancy update: +1 on dispatch fire, -1 on issue fire, unchanged when both fire.
- Flush: at the edge, all entries are invalidated and occupancy=0. Dispatch and issue in that cycle are discarded; iss_valid is 0 the following cycle. Flush takes priority over dispatch, wakeup and issue.
- Tag 0 carries no special meaning; the dispatcher never presents a not-ready source with a tag that will not be broadcast.

Optional Feature:
- RS_CDB_BYPASS_EN defined:
  - An entry whose last missing operand matches the current cdb_tag is a select candidate in the same cycle.
  - The issued operand is muxed directly from cdb_val; wakeup-to-issue latency is 0.
- RS_CDB_BYPASS_EN undefined: select uses registered rdy bits only; wakeup-to-issue latency is 1 cycle.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with disp_valid=1 -> disp_ready=0, iss_valid=0, occupancy=0. After release, disp_ready=1.
- Dispatch ready ADD (opcode 0x33, f3=0, f7=0) with src1=5, src2=7, dst=3 at cycle N, iss_ready=1 -> at N+1: iss_valid=1, operand1=5, operand2=7, iss_dst_tag=3. At N+2: occupancy=0.
- Dispatch with src1 waiting on tag 9; CDB tag 9, value 0x1234 at cycle M -> iss_valid=1 with operand1=0x1234 at M+1. With RS_CDB_BYPASS_EN: at M.
- Dispatch 8 entries all waiting on tag 4 -> disp_ready=0 and occupancy=8. CDB tag 4 -> entries issue oldest-first on consecutive cycles; disp_ready=1 the cycle after the first issue.
- Age ordering:
  - Dispatch A (waits tag 2), then B (ready); B issues.
  - In the same cycle, broadcast tag 2 and dispatch C (ready).
  - Required: A issues before C.
- Dispatch with src2 tag 6 while cdb_valid, tag 6, value 0xFF in the same cycle -> entry issues next cycle with operand2=0xFF.
- With 3 entries valid and iss_ready=0, assert flush -> next cycle: occupancy=0, iss_valid=0.
